// File: rtl/cmips_pkg.sv
// Shared definitions for the cmips pipeline control blocks.
package cmips_pkg;

  // Width of a register index (rs/rt/rd).
  localparam int REG_IDX_W = 5;

  // Width of the MDU latency counter; latencies are limited to 1..63.
  localparam int CNT_W = 6;

  // Default MDU occupancy, in EX cycles.
  localparam int DEF_MUL_LAT = 4;
  localparam int DEF_DIV_LAT = 32;

  // MDU sequencing state.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mdu_state_e;

endpackage

// File: rtl/mdu_timer.sv
// Down-counter that times an MDU operation.
// start loads len; while busy, the count falls by one per cycle.
// done flags the last cycle of the operation (busy with count at zero).
module mdu_timer
  import cmips_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             busy,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  // Load on start, then count down to zero while the operation runs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= len;
    end else if (busy && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = busy && (cnt == '0);

endmodule

// File: rtl/hazard_ctr.sv
// Pipeline hazard controller: load-use stall, MDU occupancy stall,
// taken-branch flush and a saturating count of stalled cycles.
//
// MDU issue: the ID instruction presents id_mdu_start (valid); the block
// accepts it (ready) only when the MDU is IDLE and the instruction is neither
// stalled by a load-use hazard nor flushed by a taken branch. An MDU
// instruction seen while BUSY also raises id_uses_hilo and is held in ID
// until the MDU returns to IDLE.
module hazard_ctr
  import cmips_pkg::*;
#(
  parameter int MUL_LAT = DEF_MUL_LAT,
  parameter int DIV_LAT = DEF_DIV_LAT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [REG_IDX_W-1:0] id_rs,
  input  logic [REG_IDX_W-1:0] id_rt,
  input  logic [REG_IDX_W-1:0] id_ex_rt,
  input  logic                 id_ex_memread_flag,
  input  logic                 id_mdu_start,
  input  logic                 id_mdu_is_div,
  input  logic                 id_uses_hilo,
  input  logic                 ex_branch_taken,
  output logic                 stall_if,
  output logic                 stall_id,
  output logic                 flush_id,
  output logic                 flush_ex,
  output logic                 mdu_busy,
  output logic [31:0]          stall_cycles
);

  localparam logic [CNT_W-1:0] MUL_LEN = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LEN = CNT_W'(DIV_LAT - 1);

  mdu_state_e  state_q, state_d;
  logic        load_use;
  logic        mdu_stall;
  logic        stall_req;
  logic        mdu_start_ok;
  logic        mdu_done;
  logic [31:0] stall_cnt_q;

  // Load in EX feeds a source of the instruction in ID ($0 never hazards).
  assign load_use = id_ex_memread_flag && (id_ex_rt != '0) &&
                    ((id_ex_rt == id_rs) || (id_ex_rt == id_rt));

  // HI/LO consumers (including a back-to-back MDU op) wait for the MDU.
  assign mdu_stall = (state_q == BUSY) && id_uses_hilo;

  assign stall_req = load_use || mdu_stall;

  // Never start from a stalled or flushed instruction.
  assign mdu_start_ok = (state_q == IDLE) && id_mdu_start &&
                        !load_use && !ex_branch_taken;

  mdu_timer u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mdu_start_ok),
    .len   (id_mdu_is_div ? DIV_LEN : MUL_LEN),
    .busy  (state_q == BUSY),
    .done  (mdu_done)
  );

  // MDU state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // MDU next-state: IDLE -> BUSY on accepted start, BUSY -> IDLE on done.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mdu_start_ok) state_d = BUSY;
      BUSY:    if (mdu_done)     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // mdu_busy is the registered FSM state and doubles as its debug view.
  assign mdu_busy = (state_q == BUSY);

  // Stall/flush outputs; a taken branch wins over any stall. All are held
  // low while reset is asserted.
  always_comb begin
    stall_if = 1'b0;
    stall_id = 1'b0;
    flush_id = 1'b0;
    flush_ex = 1'b0;
    if (rst_n) begin
      if (ex_branch_taken) begin
        flush_id = 1'b1;
        flush_ex = 1'b1;
      end else if (stall_req) begin
        stall_if = 1'b1;
        stall_id = 1'b1;
        flush_ex = 1'b1;
      end
    end
  end

  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (stall_if && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctr.sv
// Bench for hazard_ctr: directed scenarios plus random traffic, all checked
// against a cycle-level reference model of the hazard rules.
module tb_hazard_ctr;
  import cmips_pkg::*;

  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 32;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  id_rs = '0, id_rt = '0, id_ex_rt = '0;
  logic        id_ex_memread_flag = 1'b0, id_mdu_start = 1'b0, id_mdu_is_div = 1'b0;
  logic        id_uses_hilo = 1'b0, ex_branch_taken = 1'b0;
  logic        stall_if, stall_id, flush_id, flush_ex, mdu_busy;
  logic [31:0] stall_cycles;

  always #5 clk = ~clk;

  hazard_ctr #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .id_rs              (id_rs),
    .id_rt              (id_rt),
    .id_ex_rt           (id_ex_rt),
    .id_ex_memread_flag (id_ex_memread_flag),
    .id_mdu_start       (id_mdu_start),
    .id_mdu_is_div      (id_mdu_is_div),
    .id_uses_hilo       (id_uses_hilo),
    .ex_branch_taken    (ex_branch_taken),
    .stall_if           (stall_if),
    .stall_id           (stall_id),
    .stall_cycles       (stall_cycles),
    .flush_id           (flush_id),
    .flush_ex           (flush_ex),
    .mdu_busy           (mdu_busy)
  );

  // ---------------- scoreboard / reference model ----------------
  int          vectors = 0;
  int          miscompares = 0;
  logic [4:0]  exp_q[$];     // {stall_if, stall_id, flush_id, flush_ex, mdu_busy}
  int          mdu_left = 0; // MDU cycles still to run
  longint      exp_stall = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic model_load_use();
    return id_ex_memread_flag && (id_ex_rt != 0) &&
           ((id_ex_rt == id_rs) || (id_ex_rt == id_rt));
  endfunction

  task automatic model_reset();
    mdu_left  = 0;
    exp_stall = 0;
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    id_rs = '0; id_rt = '0; id_ex_rt = '0;
    id_ex_memread_flag = 1'b0; id_mdu_start = 1'b0; id_mdu_is_div = 1'b0;
    id_uses_hilo = 1'b0; ex_branch_taken = 1'b0;
  endtask

  // Called at a negedge with inputs set: checks outputs, advances one clock.
  task automatic cycle();
    logic       lu, busy, hold, stall;
    logic [4:0] got;
    #1;
    lu    = model_load_use();
    busy  = (mdu_left > 0);
    hold  = lu || (busy && id_uses_hilo);
    stall = !ex_branch_taken && hold;
    exp_q.push_back({stall, stall, ex_branch_taken, ex_branch_taken || hold, busy});
    got = {stall_if, stall_id, flush_id, flush_ex, mdu_busy};
    check("ctrl{sif,sid,fid,fex,busy}", 32'(got), 32'(exp_q.pop_front()));
    check("stall_cycles", stall_cycles, exp_stall[31:0]);
    @(posedge clk);
    if (stall && exp_stall < 64'hFFFF_FFFF) exp_stall++;
    if (mdu_left > 0) mdu_left--;
    else if (id_mdu_start && !lu && !ex_branch_taken)
      mdu_left = id_mdu_is_div ? DIV_LAT : MUL_LAT;
    @(negedge clk);
  endtask

  task automatic random_inputs();
    id_rs              = 5'($urandom_range(0, 3));
    id_rt              = 5'($urandom_range(0, 3));
    id_ex_rt           = 5'($urandom_range(0, 3));
    id_ex_memread_flag = ($urandom_range(0, 2) == 0);
    id_mdu_start       = ($urandom_range(0, 5) == 0);
    id_mdu_is_div      = ($urandom_range(0, 3) == 0);
    id_uses_hilo       = id_mdu_start || ($urandom_range(0, 3) == 0);
    ex_branch_taken    = ($urandom_range(0, 7) == 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int     busy_n;
    longint base;

    // Reset state, with inputs that would otherwise cause a stall.
    idle_inputs();
    id_ex_memread_flag = 1'b1; id_ex_rt = 5'd5; id_rs = 5'd5; id_uses_hilo = 1'b1;
    #1;
    check("reset stall_if", 32'(stall_if), 32'd0);
    check("reset flush_ex", 32'(flush_ex), 32'd0);
    check("reset mdu_busy", 32'(mdu_busy), 32'd0);
    check("reset stall_cycles", stall_cycles, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    idle_inputs();
    cycle();

    // Load-use: one stall cycle, then the load leaves EX.
    id_ex_memread_flag = 1'b1; id_ex_rt = 5'd5; id_rs = 5'd5;
    #1 check("load_use stall_if", 32'(stall_if), 32'd1);
    cycle();
    idle_inputs(); id_rs = 5'd5;
    cycle();
    // $0 destination is never a hazard.
    id_ex_memread_flag = 1'b1; id_ex_rt = 5'd0; id_rs = 5'd0;
    #1 check("load_use r0 stall_if", 32'(stall_if), 32'd0);
    cycle();

    // Mult followed by mfhi: 4 busy cycles, 4 stalls.
    idle_inputs();
    base = exp_stall;
    id_mdu_start = 1'b1; id_uses_hilo = 1'b1;
    cycle();
    id_mdu_start = 1'b0;
    busy_n = 0;
    for (int i = 0; i < MUL_LAT + 2; i++) begin
      #1 if (mdu_busy) busy_n++;
      cycle();
    end
    check("mult busy cycles", 32'(busy_n), 32'(MUL_LAT));
    check("mult stall count", stall_cycles, 32'(base + MUL_LAT));

    // Div with independent instructions: 32 busy cycles, no stalls.
    idle_inputs();
    base = exp_stall;
    id_mdu_start = 1'b1; id_mdu_is_div = 1'b1; id_uses_hilo = 1'b1;
    cycle();
    idle_inputs();
    busy_n = 0;
    for (int i = 0; i < DIV_LAT + 3; i++) begin
      id_rs = 5'($urandom_range(0, 31));
      #1 if (mdu_busy) busy_n++;
      cycle();
    end
    check("div busy cycles", 32'(busy_n), 32'(DIV_LAT));
    check("div no stall", stall_cycles, 32'(base));

    // Taken branch over a load-use hazard and an MDU start.
    idle_inputs();
    id_ex_memread_flag = 1'b1; id_ex_rt = 5'd5; id_rs = 5'd5;
    id_mdu_start = 1'b1; id_uses_hilo = 1'b1; ex_branch_taken = 1'b1;
    #1;
    check("branch flush_id", 32'(flush_id), 32'd1);
    check("branch flush_ex", 32'(flush_ex), 32'd1);
    check("branch stall_if", 32'(stall_if), 32'd0);
    cycle();
    idle_inputs();
    #1 check("branch no mdu start", 32'(mdu_busy), 32'd0);
    cycle();

    // Reset in the middle of a divide.
    id_mdu_start = 1'b1; id_mdu_is_div = 1'b1; id_uses_hilo = 1'b1;
    cycle();
    idle_inputs();
    repeat (9) cycle();
    id_uses_hilo = 1'b1;
    rst_n = 1'b0;
    #1;
    check("async reset mdu_busy", 32'(mdu_busy), 32'd0);
    check("async reset stall_if", 32'(stall_if), 32'd0);
    check("async reset stall_cycles", stall_cycles, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (3) cycle();

    // Saturation of the stall counter.
    idle_inputs();
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1 release dut.stall_cnt_q;
    exp_stall = 64'hFFFF_FFFE;
    id_ex_memread_flag = 1'b1; id_ex_rt = 5'd7; id_rt = 5'd7;
    repeat (3) cycle();
    idle_inputs();
    #1 check("stall_cycles saturated", stall_cycles, 32'hFFFF_FFFF);
    cycle();

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      random_inputs();
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Overall time limit so the run always ends.
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hazard_ctr.md
HAZARD_CTR -- requirements
Module: hazard_ctr

Interface
REQ-001 The block SHALL take these parameters:
- MUL_LAT, default 4: EX cycles a mult/multu occupies the MDU.
- DIV_LAT, default 32: EX cycles a div/divu occupies the MDU.
- Legal range for both: 1..63.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 The block SHALL have these ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- id_rs  in  5  rs of the instruction in ID.
- id_rt  in  5  rt of the instruction in ID.
- id_ex_rt  in  5  destination of the instruction in EX.
- id_ex_memread_flag  in  1  instruction in EX is a load.
- id_mdu_start  in  1  ID holds mult/multu/div/divu.
- id_mdu_is_div  in  1  ID MDU operation is a divide.
- id_uses_hilo  in  1  ID holds mfhi/mflo/mthi/mtlo/mult/div.
- ex_branch_taken  in  1  branch/jump resolved taken in EX.
- stall_if  out  1  hold PC.
- stall_id  out  1  hold IF/ID register.
- flush_id  out  1  zero IF/ID register.
- flush_ex  out  1  insert bubble into ID/EX.
- mdu_busy  out  1  MDU operation in progress.
- stall_cycles  out  32  saturating count of stalled cycles.

Function
REQ-010 The block SHALL assert load_use when id_ex_memread_flag=1, id_ex_rt!=0 and (id_ex_rt==id_rs or id_ex_rt==id_rt); this is combinational.
REQ-011 On load_use the block SHALL assert stall_if=stall_id=flush_ex=1 in the same cycle; the stall lasts exactly one cycle, after which the forwarding unit supplies the value from MEM/WB.
REQ-012 The block SHALL contain an FSM with states IDLE and BUSY, plus a 6-bit down-counter cnt.
REQ-013 IDLE->BUSY: id_mdu_start=1, load_use=0 and ex_branch_taken=0 at a clock edge; cnt then loads DIV_LAT-1 if id_mdu_is_div=1, else MUL_LAT-1.
REQ-014 In BUSY, cnt SHALL decrement each cycle; BUSY->IDLE occurs at the edge where cnt==0. With LAT=1, the block enters BUSY for exactly one cycle.
REQ-015 mdu_busy SHALL be 1 exactly while state==BUSY (registered output).
REQ-016 While BUSY and id_uses_hilo=1, the block SHALL assert stall_if=stall_id=flush_ex=1; this covers a second mult/div issued back-to-back.
REQ-017 ex_branch_taken=1 SHALL assert flush_id=flush_ex=1 and force stall_if=stall_id=0 in that cycle.
- Branch flush has priority over load_use and MDU stalls.
- A running MDU operation is not cancelled by the flush.
REQ-018 The block SHALL not start an MDU operation from an instruction being flushed (REQ-013 gating).
REQ-019 stall_cycles SHALL increment by 1 on every edge where stall_if=1, and saturate at 32'hFFFF_FFFF.
REQ-020 All stall/flush outputs SHALL be combinational from state, cnt and inputs, with no other latency.

Reset
REQ-030 rst_n=0 SHALL asynchronously force the following, independent of clk:
- state=IDLE, cnt=0, mdu_busy=0, stall_cycles=0.
- stall_if, stall_id, flush_id and flush_ex all 0.
REQ-031 Reset asserted mid-BUSY SHALL abandon the operation; after release the block starts in IDLE with no residual stall.

Structure
REQ-040 The following SHALL live in shared package cmips_pkg:
- FSM state encoding (IDLE=1'b0, BUSY=1'b1).
- Default MUL_LAT/DIV_LAT constants.
- Register-index width (5).
REQ-041 The latency counter SHALL be a sub-module mdu_timer with these ports: start, len, busy, done.
REQ-042 All other logic SHALL stay flat in hazard_ctr.

Verification
REQ-050 Load-use scenario:
- Stimulus: id_ex_memread_flag=1, id_ex_rt=5, id_rs=5.
- Required response: one cycle of stall_if=stall_id=flush_ex=1.
- Negative case: id_ex_rt=0 -> no stall.
REQ-051 Mult then mfhi scenario:
- Stimulus: id_mdu_start=1 with is_div=0, then id_uses_hilo=1 on the next cycle.
- Required response: mdu_busy=1 for 4 cycles; stall_if=1 for 4 cycles; stall_cycles=4.
REQ-052 Div scenario:
- Stimulus: div issued.
- Required response: mdu_busy=1 for exactly 32 cycles.
- Independent instructions (id_uses_hilo=0) are never stalled.
REQ-053 Branch-over-stall scenario:
- Stimulus: ex_branch_taken=1 while load_use=1.
- Required response: flush_id=flush_ex=1, stall_if=0.
- Same case with id_mdu_start=1: mdu_busy stays 0.
REQ-054 Reset-mid-BUSY scenario:
- Stimulus: rst_n low for 1 cycle at cycle 10 of a div.
- Required response: mdu_busy=0 immediately (asynchronously), stall_cycles=0, no stall after release.
REQ-055 Saturation scenario:
- Stimulus: force stall_cycles to 32'hFFFF_FFFE, then apply 3 stall cycles.
- Required response: stall_cycles reads 32'hFFFF_FFFF.
